// File: rtl/axi_grid_pkg.sv
// Shared types and helpers for AXI-grid arbiters: default flit width,
// the arbiter state encoding and the pointer-width helper.
package axi_grid_pkg;

  localparam int unsigned FLIT_W_DEF = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Index width for n requesters; never below one bit so ports stay legal.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_grid_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// wrapping to index 0, as one-hot grant plus binary index.
module axi_grid_rr_pick
  import axi_grid_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic          w_hi_any;
  logic [PW-1:0] w_hi_idx;
  logic [PW-1:0] w_lo_idx;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    o_any    = 1'b0;
    // Descending scan so the lowest qualifying index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any    = 1'b1;
        w_lo_idx = PW'(i);
        if (PW'(i) >= i_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = PW'(i);
        end
      end
    end
    o_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    o_gnt = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = o_any && (o_idx == PW'(i));
    end
  end

endmodule

// File: rtl/axi_grid_inj_arb.sv
// Packet-locked round-robin arbiter sharing one grid injection port among
// NUM_SRC flit sources; zero-latency mux, registered lock and pointer.
module axi_grid_inj_arb
  import axi_grid_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned FLIT_W  = FLIT_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic [NUM_SRC-1:0][FLIT_W-1:0]  src_flit_i,
  input  logic [NUM_SRC-1:0]              src_last_i,
  output logic                            dst_valid_o,
  input  logic                            dst_ready_i,
  output logic [FLIT_W-1:0]               dst_flit_o,
  output logic                            dst_last_o,
  output logic [NUM_SRC-1:0]              grant_o,
  output logic                            busy_o
);

  localparam int unsigned      PTR_W    = ptr_w(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  arb_state_e       r_state;
  logic [PTR_W-1:0] r_lock_idx;
  logic [PTR_W-1:0] r_rr_ptr;
  logic             r_busy;

  logic [NUM_SRC-1:0] w_pick_gnt;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_lock;
  logic [PTR_W-1:0]   w_gidx;
  logic               w_fire_last;
  logic [PTR_W-1:0]   w_next_ptr;

  axi_grid_rr_pick #(.N(NUM_SRC)) u_pick (
    .i_req (src_valid_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_lock = (r_state == ARB_LOCK);
  assign w_gidx = w_lock ? r_lock_idx : w_pick_idx;

  // While locked the grant stays on lock_idx even if its valid drops.
  always_comb begin
    grant_o     = '0;
    dst_flit_o  = '0;
    dst_last_o  = 1'b0;
    dst_valid_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_o[i] = w_lock ? (r_lock_idx == PTR_W'(i)) : w_pick_gnt[i];
      if (grant_o[i]) begin
        dst_flit_o  = src_flit_i[i];
        dst_last_o  = src_last_i[i];
        dst_valid_o = src_valid_i[i];
      end
    end
  end

  assign src_ready_o = grant_o & {NUM_SRC{dst_ready_i}};
  assign w_fire_last = dst_valid_o & dst_ready_i & dst_last_o;
  assign w_next_ptr  = (w_gidx == LAST_IDX) ? '0 : w_gidx + PTR_W'(1);
  assign busy_o      = r_busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= ARB_IDLE;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            if (w_fire_last) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state    <= ARB_LOCK;
              r_lock_idx <= w_pick_idx;
              r_busy     <= 1'b1;
            end
          end
        end
        ARB_LOCK: begin
          if (w_fire_last) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_grid_inj_arb.sv
// Scoreboard bench for axi_grid_inj_arb: per-source flit queues drive the
// inputs, expected grant order is queued by each test and popped on fire.
module tb_axi_grid_inj_arb;

  typedef struct packed {
    logic [63:0] flit;
    logic        last;
  } flit_t;

  typedef struct packed {
    int          src;
    logic [63:0] flit;
    logic        last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       src_valid_i, src_ready_o, src_last_i, grant_o;
  logic [3:0][63:0] src_flit_i;
  logic             dst_valid_o, dst_ready_i, dst_last_o, busy_o;
  logic [63:0]      dst_flit_o;

  logic [2:0]       v3, r3, l3, g3;
  logic [2:0][63:0] f3;
  logic             dv3, rdy3, dl3, b3;
  logic [63:0]      df3;

  int checks   = 0;
  int failures = 0;

  flit_t src_q[4][$];
  exp_t  sb[$];

  logic [3:0]  s_grant, s_ready;
  logic        s_busy, s_valid, s_fire;
  logic [63:0] s_flit;

  always #5 clk = ~clk;

  axi_grid_inj_arb #(.NUM_SRC(4), .FLIT_W(64)) u_dut (
    .clk_i       (clk),
    .arst_ni     (rst_n),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_flit_i  (src_flit_i),
    .src_last_i  (src_last_i),
    .dst_valid_o (dst_valid_o),
    .dst_ready_i (dst_ready_i),
    .dst_flit_o  (dst_flit_o),
    .dst_last_o  (dst_last_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  axi_grid_inj_arb #(.NUM_SRC(3), .FLIT_W(64)) u_dut3 (
    .clk_i       (clk),
    .arst_ni     (rst_n),
    .src_valid_i (v3),
    .src_ready_o (r3),
    .src_flit_i  (f3),
    .src_last_i  (l3),
    .dst_valid_o (dv3),
    .dst_ready_i (rdy3),
    .dst_flit_o  (df3),
    .dst_last_o  (dl3),
    .grant_o     (g3),
    .busy_o      (b3)
  );

  task automatic add_src(input int s, input logic [63:0] f, input logic l);
    flit_t e;
    e.flit = f;
    e.last = l;
    src_q[s].push_back(e);
  endtask

  task automatic sb_push(input int s, input logic [63:0] f, input logic l);
    exp_t e;
    e.src  = s;
    e.flit = f;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic clear_all();
    for (int s = 0; s < 4; s++) src_q[s].delete();
    sb.delete();
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step();
    exp_t       e;
    logic [3:0] eg;
    logic [3:0] pops;
    for (int s = 0; s < 4; s++) begin
      if (src_q[s].size() > 0) begin
        src_valid_i[s] = 1'b1;
        src_flit_i[s]  = src_q[s][0].flit;
        src_last_i[s]  = src_q[s][0].last;
      end else begin
        src_valid_i[s] = 1'b0;
        src_flit_i[s]  = '0;
        src_last_i[s]  = 1'b0;
      end
    end
    @(negedge clk);
    s_grant = grant_o;
    s_ready = src_ready_o;
    s_busy  = busy_o;
    s_valid = dst_valid_o;
    s_flit  = dst_flit_o;
    s_fire  = dst_valid_o && dst_ready_i;
    if (s_fire) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got flit=%h grant=%b required no transfer", dst_flit_o, grant_o);
      end else begin
        e  = sb.pop_front();
        eg = 4'b0001 << e.src;
        if (dst_flit_o !== e.flit || dst_last_o !== e.last || grant_o !== eg) begin
          failures++;
          $display("FAIL sb_flit got flit=%h last=%b grant=%b required flit=%h last=%b grant=%b",
                   dst_flit_o, dst_last_o, grant_o, e.flit, e.last, eg);
        end
      end
    end
    pops = src_ready_o & src_valid_i;
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) if (pops[s]) void'(src_q[s].pop_front());
  endtask

  task automatic drain(input int budget);
    int  n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      pending = (sb.size() != 0);
      for (int s = 0; s < 4; s++) if (src_q[s].size() != 0) pending = 1'b1;
      if (pending) begin
        step();
        n++;
      end
    end
    pending = (sb.size() != 0);
    for (int s = 0; s < 4; s++) if (src_q[s].size() != 0) pending = 1'b1;
    checks++;
    if (pending) begin
      failures++;
      $display("FAIL drain_timeout got pending_expected=%0d required 0 within %0d cycles", sb.size(), budget);
    end
  endtask

  task automatic do_reset();
    clear_all();
    src_valid_i = '0;
    src_last_i  = '0;
    src_flit_i  = '0;
    v3 = '0; l3 = '0; f3 = '0; rdy3 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_valid_i = '0; src_last_i = '0; src_flit_i = '0;
    v3 = '0; l3 = '0; f3 = '0; rdy3 = 1'b0;
    dst_ready_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || grant_o !== 4'b0000 || dst_valid_o !== 1'b0 || src_ready_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b grant=%b valid=%b ready=%b required 0 0000 0 0000",
               busy_o, grant_o, dst_valid_o, src_ready_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (s_grant !== 4'b0000 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got grant=%b valid=%b busy=%b required 0000 0 0", s_grant, s_valid, s_busy);
    end
  endtask

  task automatic test_single_packet();
    logic [3:0] exp_busy;
    do_reset();
    dst_ready_i = 1'b1;
    add_src(0, 64'h11, 1'b0); add_src(0, 64'h22, 1'b0); add_src(0, 64'h33, 1'b1);
    sb_push(0, 64'h11, 1'b0); sb_push(0, 64'h22, 1'b0); sb_push(0, 64'h33, 1'b1);
    exp_busy = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (s_busy !== exp_busy[c]) begin
        failures++;
        $display("FAIL sp_busy_c%0d got=%b required=%b", c, s_busy, exp_busy[c]);
      end
    end
    checks++;
    if (s_grant !== 4'b0000) begin
      failures++;
      $display("FAIL sp_grant_after got=%b required=0000", s_grant);
    end
    // Pointer now 1: src1 must beat src0.
    add_src(0, 64'hAA, 1'b1); add_src(1, 64'hBB, 1'b1);
    sb_push(1, 64'hBB, 1'b1); sb_push(0, 64'hAA, 1'b1);
    drain(10);
  endtask

  task automatic test_round_robin();
    int fires;
    do_reset();
    dst_ready_i = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 4; s++) begin
        add_src(s, 64'h100 + 64'(s * 16 + k), 1'b1);
        sb_push(s, 64'h100 + 64'(s * 16 + k), 1'b1);
      end
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_fire) fires++;
    end
    checks++;
    if (fires !== 8) begin
      failures++;
      $display("FAIL rr_no_bubbles got fires=%0d required=8", fires);
    end
    drain(10);
  endtask

  task automatic test_backpressure();
    do_reset();
    dst_ready_i = 1'b0;
    add_src(1, 64'hA5, 1'b1);
    sb_push(1, 64'hA5, 1'b1); sb_push(0, 64'h5A, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) add_src(0, 64'h5A, 1'b1);
      step();
      checks++;
      if (s_grant !== 4'b0010 || s_flit !== 64'hA5 || s_ready !== 4'b0000 || s_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall_c%0d got grant=%b flit=%h ready=%b valid=%b required 0010 a5 0000 1",
                 c, s_grant, s_flit, s_ready, s_valid);
      end
    end
    dst_ready_i = 1'b1;
    step();
    checks++;
    if (s_fire !== 1'b1 || s_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_accept got fire=%b ready=%b required 1 0010", s_fire, s_ready);
    end
    step();
    checks++;
    if (s_grant !== 4'b0001) begin
      failures++;
      $display("FAIL bp_next_grant got=%b required=0001", s_grant);
    end
    drain(10);
  endtask

  task automatic test_packet_lock();
    do_reset();
    dst_ready_i = 1'b1;
    add_src(1, 64'hC0, 1'b1);
    sb_push(1, 64'hC0, 1'b1);
    drain(5);
    // Pointer is 2: src2 wins, locks for 4 flits, then src3, then src0.
    add_src(0, 64'hD0, 1'b1);
    add_src(3, 64'hD3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add_src(2, 64'hE0 + 64'(k), k == 3);
      sb_push(2, 64'hE0 + 64'(k), k == 3);
    end
    sb_push(3, 64'hD3, 1'b1);
    sb_push(0, 64'hD0, 1'b1);
    drain(15);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    dst_ready_i = 1'b1;
    add_src(1, 64'h31, 1'b0); add_src(1, 64'h32, 1'b0); add_src(1, 64'h33, 1'b1);
    sb_push(1, 64'h31, 1'b0);
    step();
    checks++;
    if (busy_o !== 1'b1 || grant_o !== 4'b0010) begin
      failures++;
      $display("FAIL rmp_locked got busy=%b grant=%b required 1 0010", busy_o, grant_o);
    end
    clear_all();
    src_valid_i = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
      failures++;
      $display("FAIL rmp_async got busy=%b grant=%b required 0 0000", busy_o, grant_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_src(0, 64'h41, 1'b1);
    sb_push(0, 64'h41, 1'b1);
    step();
    checks++;
    if (s_grant !== 4'b0001) begin
      failures++;
      $display("FAIL rmp_after got grant=%b required=0001", s_grant);
    end
    drain(5);
  endtask

  task automatic test_nsrc3_wrap();
    do_reset();
    rdy3 = 1'b1;
    v3 = 3'b100; l3 = 3'b100; f3[2] = 64'h77;
    @(negedge clk);
    checks++;
    if (g3 !== 3'b100 || dv3 !== 1'b1 || df3 !== 64'h77) begin
      failures++;
      $display("FAIL n3_src2 got grant=%b valid=%b flit=%h required 100 1 77", g3, dv3, df3);
    end
    @(posedge clk);
    #1;
    v3 = 3'b011; l3 = 3'b011; f3[0] = 64'h70; f3[1] = 64'h71;
    @(negedge clk);
    checks++;
    if (g3 !== 3'b001 || df3 !== 64'h70 || r3 !== 3'b001) begin
      failures++;
      $display("FAIL n3_wrap got grant=%b flit=%h ready=%b required 001 70 001", g3, df3, r3);
    end
    @(posedge clk);
    #1;
    v3 = 3'b101; l3 = 3'b101; f3[2] = 64'h72;
    @(negedge clk);
    checks++;
    if (g3 !== 3'b100 || df3 !== 64'h72) begin
      failures++;
      $display("FAIL n3_ptr1 got grant=%b flit=%h required 100 72", g3, df3);
    end
    @(posedge clk);
    #1;
    v3 = '0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_reset_mid_packet();
    test_nsrc3_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time=%0t required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_grid_inj_arb.md
Name: axi_grid_inj_arb

Overview:
Round-robin, packet-locked arbiter that shares one AXI-grid network injection port among NUM_SRC flit sources, such as per-channel SNI packetizers (AW/W/AR). It grants one source at a time and holds the grant until that source's last flit is accepted, so packets never interleave. It sits between the SNI packetizers and the grid router local input port. Zero-latency mux with a registered lock and priority pointer.

Parameters:
NUM_SRC, 4, number of requesting sources (>=1, need not be a power of 2)
FLIT_W, 64, flit payload width in bits

Ports:
clk_i  in  1  clock, all state updates on rising edge
arst_ni  in  1  asynchronous active-low reset
src_valid_i  in  NUM_SRC  per-source flit valid
src_ready_o  out  NUM_SRC  per-source flit accept
src_flit_i  in  NUM_SRC x FLIT_W  per-source flit payload
src_last_i  in  NUM_SRC  per-source last-flit-of-packet marker
dst_valid_o  out  1  flit valid toward router
dst_ready_i  in  1  router accepts flit
dst_flit_o  out  FLIT_W  granted source payload
dst_last_o  out  1  granted source last marker
grant_o  out  NUM_SRC  one-hot current grant (all-zero when no winner)
busy_o  out  1  high while in LOCK state

Behaviour:
- State: fsm {IDLE, LOCK}; lock_idx; rr_ptr. rr_ptr width is max(1,$clog2(NUM_SRC)).
- Reset (arst_ni low, async): fsm=IDLE, lock_idx=0, rr_ptr=0. busy_o=0.
  - Remaining outputs are combinational from IDLE state.
  - Sources must hold src_valid_i low during reset, giving dst_valid_o=0, grant_o=0, src_ready_o=0.
- Winner selection (IDLE):
  - winner = first index i with src_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... NUM_SRC-1, 0, ... rr_ptr-1.
  - No requester: grant_o=0, dst_valid_o=0.
- Grant index: gidx = winner in IDLE, lock_idx in LOCK.
- Datapath (combinational, 0-cycle latency):
  - dst_flit_o=src_flit_i[gidx], dst_last_o=src_last_i[gidx], dst_valid_o=src_valid_i[gidx] (gated by a valid grant).
  - src_ready_o[gidx]=dst_ready_i; all other src_ready_o bits are 0.
- Handshake: fire = dst_valid_o & dst_ready_i.
- IDLE transitions:
  - Winner exists and fire & last: stay IDLE, rr_ptr = winner+1, wrapping NUM_SRC-1 -> 0.
  - Winner exists and not (fire & last): go to LOCK, lock_idx = winner. This covers a mid-packet flit or a stall, so the grant never moves while valid is pending.
- LOCK transitions:
  - Grant is frozen regardless of other requests.
  - On fire & last: go to IDLE, rr_ptr = lock_idx+1 (wrapped).
  - src_valid_i[lock_idx] dropping between flits is legal: dst_valid_o=0 and the state holds.
- Same-cycle fire&last plus new requests: the new winner is evaluated next cycle with the updated rr_ptr. There are no back-to-back bubbles from other sources beyond that single re-evaluation, which is combinational.
- Fairness: each requesting source is granted within NUM_SRC-1 packets of others.
- NUM_SRC=1: rr_ptr is constant 0; only the lock behaviour applies.
- Reset mid-packet: the lock is dropped immediately (async). The upstream source must be reset in the same domain.
- Stability: while dst_valid_o & !dst_ready_i, dst_flit_o, dst_last_o and grant_o are stable, provided sources obey the valid/ready rule.

Decomposition:
- axi_grid_pkg gets the flit-width localparam and arb state enum (IDLE/LOCK) typedef for reuse by other grid arbiters.
- Sub-module axi_grid_rr_pick (combinational): inputs req vector + rr_ptr, outputs one-hot grant + index + any. Reused by router output arbiters.

Test Plan:
- Single packet: src0 sends 3 flits 0x11,0x22,0x33 (last on 0x33), dst_ready_i=1 -> dst_flit_o 0x11,0x22,0x33 on consecutive cycles; grant_o=0001; busy_o=1 during cycles 1-2; rr_ptr=1 after.
- Round robin: all 4 sources hold single-flit packets, ready=1 -> grants 0,1,2,3,0,1 one per cycle, no bubbles.
- Backpressure: src1 valid with 0xA5, dst_ready_i=0 for 5 cycles, src0 asserts valid at cycle 2 -> grant_o stays 0010, dst_flit_o=0xA5 stable, src_ready_o=0; the flit is accepted on cycle 6; src0 is granted next.
- Packet lock: src2 sends a 4-flit packet, src0 and src3 are valid throughout -> no interleaving. After src2's last flit, src3 is granted before src0.
- Reset mid-packet: assert arst_ni low during flit 2 of a src1 packet -> busy_o=0 and grant_o=0 immediately. After release with src0 valid, grant_o=0001.
- NUM_SRC=3 wrap: src2 completes a packet, then src0 and src1 request -> src0 is granted (rr_ptr 2->0).
